// File: rtl/cpu_control_fsm.sv
// Control sequencer for the 16-bit RISC datapath.
// One instruction is latched on the start handshake, decoded, and then walked
// through the datapath one control state per clock. All control outputs are
// Moore: they depend only on the current state and the latched instruction.
//
// state  | meaning
// -------+------------------------------------------------------------
// WAIT   | idle, w=1; s=1 latches the instruction word into IR
// DECODE | classify IR; illegal encodings pulse err and return to WAIT
// GETA   | read Rn into the A register
// GETB   | read Rm into the B register
// ALU    | shift B, run the ALU, load C (or status only for CMP)
// WRREG  | write C back to Rd
// WRIMM  | write sign-extended imm8 to Rn
// HALT   | parked until reset, s ignored
module cpu_control_fsm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_i,
  input  logic [15:0] in_i,
  output logic        w_o,
  output logic        halt_o,
  output logic        err_o,
  output logic [2:0]  readnum_o,
  output logic [2:0]  writenum_o,
  output logic        write_o,
  output logic [1:0]  vsel_o,
  output logic        loada_o,
  output logic        loadb_o,
  output logic        loadc_o,
  output logic        loads_o,
  output logic        asel_o,
  output logic        bsel_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  shift_o,
  output logic [15:0] sximm8_o
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GETA   = 3'd2,
    ST_GETB   = 3'd3,
    ST_ALU    = 3'd4,
    ST_WRREG  = 3'd5,
    ST_WRIMM  = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // Write-data select encodings
  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_C      = 2'b11;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign sximm8_o = {{8{ir_q[7]}}, ir_q[7:0]};

  // Instruction classes
  logic dec_mov_imm;
  logic dec_mov_reg;
  logic dec_two_src;   // ADD, CMP, AND: need both A and B
  logic dec_mvn;
  logic dec_cmp;
  logic dec_halt;
  logic dec_illegal;

  assign dec_mov_imm = (opcode == OPC_MOV) && (op == 2'b10);
  assign dec_mov_reg = (opcode == OPC_MOV) && (op == 2'b00);
  assign dec_two_src = (opcode == OPC_ALU) && (op != 2'b11);
  assign dec_mvn     = (opcode == OPC_ALU) && (op == 2'b11);
  assign dec_cmp     = (opcode == OPC_ALU) && (op == 2'b01);
  assign dec_halt    = (opcode == OPC_HALT);
  assign dec_illegal = !(dec_mov_imm || dec_mov_reg || dec_two_src ||
                         dec_mvn || dec_halt);

  // State and instruction register; reset aborts any instruction in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; IR only loads on the start handshake in WAIT
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_WAIT: begin
        if (s_i) begin
          ir_d    = in_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_mov_imm) begin
          state_d = ST_WRIMM;
        end else if (dec_mov_reg || dec_mvn) begin
          state_d = ST_GETB;
        end else if (dec_two_src) begin
          state_d = ST_GETA;
        end else if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GETA:  state_d = ST_GETB;
      ST_GETB:  state_d = ST_ALU;
      ST_ALU:   state_d = dec_cmp ? ST_WAIT : ST_WRREG;
      ST_WRREG: state_d = ST_WAIT;
      ST_WRIMM: state_d = ST_WAIT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Moore control outputs decoded from state and IR
  always_comb begin
    w_o        = 1'b0;
    halt_o     = 1'b0;
    err_o      = 1'b0;
    readnum_o  = 3'b000;
    writenum_o = 3'b000;
    write_o    = 1'b0;
    vsel_o     = VSEL_MDATA;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    alu_op_o   = 2'b00;
    shift_o    = 2'b00;
    case (state_q)
      ST_WAIT: begin
        w_o = 1'b1;
      end
      ST_DECODE: begin
        err_o = dec_illegal;
      end
      ST_GETA: begin
        readnum_o = rn;
        loada_o   = 1'b1;
      end
      ST_GETB: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
      end
      ST_ALU: begin
        shift_o  = sh;
        // MOV-reg reuses ADD with A forced to zero; MVN only needs B
        alu_op_o = (opcode == OPC_ALU) ? op : 2'b00;
        asel_o   = dec_mov_reg || dec_mvn;
        if (dec_cmp) begin
          loads_o = 1'b1;
        end else begin
          loadc_o = 1'b1;
        end
      end
      ST_WRREG: begin
        vsel_o     = VSEL_C;
        writenum_o = rd;
        write_o    = 1'b1;
      end
      ST_WRIMM: begin
        vsel_o     = VSEL_SXIMM8;
        writenum_o = rn;
        write_o    = 1'b1;
      end
      ST_HALT: begin
        halt_o = 1'b1;
      end
      default: begin
        w_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed cases plus a random
// instruction stream, each compared cycle by cycle against a list of expected
// control vectors derived from the instruction's meaning.
module tb_cpu_control_fsm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s_i;
  logic [15:0] in_i;
  logic        w_o, halt_o, err_o, write_o;
  logic [2:0]  readnum_o, writenum_o;
  logic [1:0]  vsel_o, alu_op_o, shift_o;
  logic        loada_o, loadb_o, loadc_o, loads_o, asel_o, bsel_o;
  logic [15:0] sximm8_o;

  cpu_control_fsm dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_i        (s_i),
    .in_i       (in_i),
    .w_o        (w_o),
    .halt_o     (halt_o),
    .err_o      (err_o),
    .readnum_o  (readnum_o),
    .writenum_o (writenum_o),
    .write_o    (write_o),
    .vsel_o     (vsel_o),
    .loada_o    (loada_o),
    .loadb_o    (loadb_o),
    .loadc_o    (loadc_o),
    .loads_o    (loads_o),
    .asel_o     (asel_o),
    .bsel_o     (bsel_o),
    .alu_op_o   (alu_op_o),
    .shift_o    (shift_o),
    .sximm8_o   (sximm8_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [15:0] last_ir;

  // Observed control vector, field order matches mk()
  logic [63:0] dut_vec;
  assign dut_vec = {26'd0, w_o, halt_o, err_o, readnum_o, writenum_o, write_o,
                    vsel_o, loada_o, loadb_o, loadc_o, loads_o, asel_o, bsel_o,
                    alu_op_o, shift_o, sximm8_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    input logic w, input logic halt, input logic err,
    input logic [2:0] rdn, input logic [2:0] wrn, input logic wr,
    input logic [1:0] vsel, input logic la, input logic lb, input logic lc,
    input logic ls, input logic asel, input logic bsel,
    input logic [1:0] aluop, input logic [1:0] shift, input logic [15:0] sx);
    return {26'd0, w, halt, err, rdn, wrn, wr, vsel, la, lb, lc, ls, asel, bsel,
            aluop, shift, sx};
  endfunction

  function automatic logic [15:0] sxt(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  function automatic logic [63:0] idle_vec(input logic [15:0] ir);
    return mk(1, 0, 0, 3'd0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, sxt(ir));
  endfunction

  // Expected busy cycles (w=0) for one instruction, from its meaning
  function automatic void build(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic [15:0] sx;
    logic mov_imm, mov_reg, add_cmp_and, mvn, halt, legal, cmp;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    sx = sxt(ir);
    mov_imm     = (opc == 3'b110) && (op == 2'b10);
    mov_reg     = (opc == 3'b110) && (op == 2'b00);
    add_cmp_and = (opc == 3'b101) && (op != 2'b11);
    mvn         = (opc == 3'b101) && (op == 2'b11);
    cmp         = (opc == 3'b101) && (op == 2'b01);
    halt        = (opc == 3'b111);
    legal       = mov_imm || mov_reg || add_cmp_and || mvn || halt;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, !legal, 3'd0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, sx));
    if (mov_imm)
      exp_q.push_back(mk(0, 0, 0, 3'd0, rn, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, sx));
    if (mov_reg || add_cmp_and || mvn) begin
      if (add_cmp_and)
        exp_q.push_back(mk(0, 0, 0, rn, 3'd0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, sx));
      exp_q.push_back(mk(0, 0, 0, rm, 3'd0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, sx));
      exp_q.push_back(mk(0, 0, 0, 3'd0, 3'd0, 0, 2'd0, 0, 0, !cmp, cmp,
                         mov_reg || mvn, 0, (opc == 3'b101) ? op : 2'b00, sh, sx));
      if (!cmp)
        exp_q.push_back(mk(0, 0, 0, 3'd0, rd, 1, 2'b11, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, sx));
    end
  endfunction

  // Launch from WAIT and follow the instruction back to WAIT
  task automatic run_instr(input logic [15:0] ir, input string name);
    build(ir);
    s_i  = 1'b1;
    in_i = ir;
    @(posedge clk_i);
    #1;
    s_i  = 1'($urandom_range(0, 1));
    in_i = 16'($urandom);
    foreach (exp_q[k]) begin
      @(negedge clk_i);
      check($sformatf("%s ir=%h cyc%0d", name, ir, k), dut_vec, exp_q[k]);
      s_i  = 1'($urandom_range(0, 1));
      in_i = 16'($urandom);
    end
    @(negedge clk_i);
    check($sformatf("%s ir=%h wait", name, ir), dut_vec, idle_vec(ir));
    s_i     = 1'b0;
    last_ir = ir;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("idle", dut_vec, idle_vec(last_ir));
      in_i = 16'($urandom);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = $urandom_range(0, 6);
    case (k)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10101;
      4: r[15:11] = 5'b10110;
      5: r[15:11] = 5'b10111;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          r[15:13] = 3'($urandom_range(0, 4));
        end else begin
          r[15:13] = 3'b110;
          r[11]    = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rst_vec;
    rst_vec = mk(1, 0, 0, 3'd0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000);
    rst_i = 1'b1; s_i = 1'b0; in_i = 16'h0000; last_ir = 16'h0000;
    #12;
    check("reset", dut_vec, rst_vec);
    @(negedge clk_i); #1; rst_i = 1'b0;
    idle_cycles(1);

    // Directed cases
    run_instr(16'hD3FB, "mov_imm");
    run_instr(16'hA148, "add");
    run_instr(16'hA900, "cmp");
    run_instr(16'h0000, "illegal");
    idle_cycles(2);

    // Reset during GETB of an ADD aborts it without any write
    build(16'hA148);
    s_i = 1'b1; in_i = 16'hA148;
    @(posedge clk_i); #1; s_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("abort cyc%0d", k), dut_vec, exp_q[k]);
    end
    #2 rst_i = 1'b1;
    #1 check("abort async", dut_vec, rst_vec);
    @(negedge clk_i);
    check("abort held", dut_vec, rst_vec);
    #1 rst_i = 1'b0;
    last_ir = 16'h0000;
    idle_cycles(1);
    run_instr(16'hD3FB, "mov_after_abort");

    // Random stream, back-to-back and with gaps
    for (int i = 0; i < 60; i++) begin
      run_instr(rand_instr(), "rand");
      idle_cycles($urandom_range(0, 2));
    end

    // HALT parks with s toggling until reset
    build(16'hE000);
    s_i = 1'b1; in_i = 16'hE000;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("halt decode", dut_vec, exp_q[0]);
    for (int i = 0; i < 20; i++) begin
      s_i  = ~s_i;
      in_i = 16'($urandom);
      @(negedge clk_i);
      check($sformatf("halt hold%0d", i), dut_vec,
            mk(0, 1, 0, 3'd0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000));
    end
    s_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 check("halt reset", dut_vec, rst_vec);
    @(negedge clk_i); #1 rst_i = 1'b0;
    last_ir = 16'h0000;
    idle_cycles(1);
    run_instr(16'hA148, "add_after_halt");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
